// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and a valid/ready byte output.
// A held-low line after a bad stop bit reports one frame error until the line idles.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_n;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_n;
    logic [7:0]    r_data;
    logic [7:0]    w_data_n;
    logic          r_valid;
    logic          w_valid_n;
    logic          r_ferr;
    logic          w_ferr_n;
    logic          r_ovr;
    logic          w_ovr_n;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_rxs;
    logic          w_done;
    logic          w_half;
    logic          w_last;

    assign w_rxs  = r_sync2;
    assign w_half = (r_cnt == HALF);
    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_shift <= w_shift_n;
            r_data  <= w_data_n;
            r_valid <= w_valid_n;
            r_ferr  <= w_ferr_n;
            r_ovr   <= w_ovr_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_shift_n = r_shift;
        w_done    = 1'b0;
        w_ferr_n  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state_n = START;
                    w_cnt_n   = '0;
                end
            end
            START: begin
                if (w_half) begin
                    w_cnt_n = '0;
                    w_idx_n = '0;
                    w_state_n = w_rxs ? IDLE : DATA;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            DATA: begin
                if (w_last) begin
                    w_shift_n[r_idx] = w_rxs;
                    w_cnt_n = '0;
                    w_idx_n = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_n = STOP;
                    end
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            STOP: begin
                if (w_last) begin
                    w_cnt_n = '0;
                    if (w_rxs) begin
                        w_done    = 1'b1;
                        w_state_n = IDLE;
                    end else begin
                        // bad stop bit: drop the byte, wait out the low line
                        w_ferr_n  = 1'b1;
                        w_shift_n = '0;
                        w_state_n = BREAK;
                    end
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            BREAK: begin
                if (w_rxs) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        w_data_n  = r_data;
        w_valid_n = r_valid;
        w_ovr_n   = 1'b0;
        if (w_done && (!r_valid || rx_ready)) begin
            w_data_n  = r_shift;
            w_valid_n = 1'b1;
        end else if (w_done) begin
            w_ovr_n = 1'b1;
        end else if (r_valid && rx_ready) begin
            w_valid_n = 1'b0;
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboard of expected bytes checked at each handshake.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       rx_in    = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int vh_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int rise_cyc = -1000;
    int ov_cyc   = -1000;
    int t0;
    int t1;
    int lat0;
    logic prev_valid = 1'b0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            tick(CPB);
        end
        rx_in = stop;
        tick(CPB);
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (rx_valid === 1'b1) vh_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) begin
            ov_cnt++;
            ov_cyc = cyc;
        end
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
        prev_valid = rx_valid;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected: observed %02h expected none", rx_data);
            end else begin
                e = q.pop_front();
                chk("sb_data", 32'(rx_data), 32'(e));
            end
        end
    end

    initial begin
        tick(1);
        chk("rst_data", 32'(rx_data), 32'h0);
        chk("rst_valid", 32'(rx_valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(10);

        // single byte, ready high
        vh_cnt = 0; fe_cnt = 0;
        q.push_back(8'hA5);
        t0 = cyc;
        send_byte(8'hA5, 1'b1);
        tick(20);
        lat0 = rise_cyc - t0;
        chk("a5_vcycles", 32'(vh_cnt), 32'd1);
        chk("a5_latency", 32'(lat0 >= 152 && lat0 <= 156), 32'd1);
        chk("a5_ferr", 32'(fe_cnt), 32'd0);
        chk("a5_sb", 32'(q.size()), 32'd0);
        if (lat0 < 152 || lat0 > 156) lat0 = 155;

        // back-to-back with consumer stalled: second byte lost
        rx_ready = 1'b0;
        ov_cnt = 0;
        q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        t1 = cyc;
        send_byte(8'h81, 1'b1);
        tick(20);
        chk("ovr_count", 32'(ov_cnt), 32'd1);
        chk("ovr_time", 32'(ov_cyc - t1), 32'(lat0));
        chk("ovr_data", 32'(rx_data), 32'h3C);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        tick(3);
        chk("ovr_drain", 32'(rx_valid), 32'd0);
        chk("ovr_sb", 32'(q.size()), 32'd0);

        // short low glitch
        vh_cnt = 0; fe_cnt = 0;
        rx_in = 1'b0;
        tick(5);
        rx_in = 1'b1;
        tick(3 * CPB);
        chk("glitch_valid", 32'(vh_cnt), 32'd0);
        chk("glitch_ferr", 32'(fe_cnt), 32'd0);

        // bad stop bit, long break, then recovery
        vh_cnt = 0; fe_cnt = 0;
        send_byte(8'h55, 1'b0);
        tick(40 * CPB);
        chk("brk_ferr", 32'(fe_cnt), 32'd1);
        chk("brk_valid", 32'(vh_cnt), 32'd0);
        rx_in = 1'b1;
        tick(2 * CPB);
        q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1);
        tick(20);
        chk("brk_next_vcnt", 32'(vh_cnt), 32'd1);
        chk("brk_next_data", 32'(rx_data), 32'h0F);
        chk("brk_sb", 32'(q.size()), 32'd0);

        // reset in the middle of data bit 4 of 0xFF
        vh_cnt = 0; fe_cnt = 0; ov_cnt = 0;
        rx_in = 1'b0;
        tick(CPB);
        rx_in = 1'b1;
        tick(4 * CPB + 8);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_data", 32'(rx_data), 32'h0);
        chk("mid_rst_valid", 32'(rx_valid), 32'h0);
        chk("mid_rst_ferr", 32'(frame_err), 32'h0);
        chk("mid_rst_ovr", 32'(overrun), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(5 * CPB);
        chk("mid_vcnt", 32'(vh_cnt), 32'd0);
        chk("mid_ferr", 32'(fe_cnt), 32'd0);
        chk("mid_ovr", 32'(ov_cnt), 32'd0);
        q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        tick(20);
        chk("mid_next_data", 32'(rx_data), 32'h12);
        chk("mid_sb", 32'(q.size()), 32'd0);

        // handshake coincident with completion
        rx_ready = 1'b0;
        ov_cnt = 0;
        q.push_back(8'h77);
        send_byte(8'h77, 1'b1);
        tick(10);
        chk("hold_valid", 32'(rx_valid), 32'd1);
        chk("hold_data", 32'(rx_data), 32'h77);
        q.push_back(8'h99);
        fork
            send_byte(8'h99, 1'b1);
            begin
                tick(lat0 - 1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        chk("coin_data", 32'(rx_data), 32'h99);
        chk("coin_valid", 32'(rx_valid), 32'd1);
        chk("coin_ovr", 32'(ov_cnt), 32'd0);
        chk("coin_sb1", 32'(q.size()), 32'd1);
        rx_ready = 1'b1;
        tick(3);
        chk("coin_drain", 32'(rx_valid), 32'd0);
        chk("coin_sb0", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge only.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port rx_in, input, 1 bit: asynchronous serial line, idle high, 8N1 format, LSB first.
REQ-005 SHALL have port rx_data, output, 8 bits: received byte, held stable while rx_valid=1.
REQ-006 SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-007 SHALL have port rx_ready, input, 1 bit: the consumer accepts the byte in any cycle where rx_valid=1 and rx_ready=1.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a bad stop bit is sampled.
REQ-009 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped.

Function
REQ-010 SHALL pass rx_in through a 2-flop synchronizer; all logic uses only the synchronized value rxs.
REQ-011 SHALL implement the states IDLE, START, DATA, STOP and BREAK, with a bit-period counter and a 3-bit bit index.
REQ-012 IDLE: when rxs=0, SHALL go to START with the counter cleared.
REQ-013 START: at count CLKS_PER_BIT/2-1 SHALL sample rxs; if 0, go to DATA with counter and index cleared; if 1 (glitch), go to IDLE with no output change.
REQ-014 DATA: at count CLKS_PER_BIT-1 SHALL sample rxs into shift bit[index], clear the counter and increment the index; after index 7, go to STOP.
REQ-015 STOP: at count CLKS_PER_BIT-1 SHALL sample rxs; if 1, complete the byte and go to IDLE; if 0, pulse frame_err, discard the byte and go to BREAK.
REQ-016 BREAK: SHALL stay until rxs=1, then go to IDLE, so a held-low line produces exactly one frame_err.
REQ-017 On completion, rx_data SHALL load the shift register and rx_valid SHALL assert in the following cycle.
REQ-018 rx_valid SHALL clear in the cycle after a valid&&rx_ready handshake; rx_data SHALL not change while rx_valid=1 except by a handshake-coincident load.
REQ-019 Completion while rx_valid=1 and rx_ready=0: SHALL drop the new byte, keep the old byte and pulse overrun for 1 cycle.
REQ-020 Completion while rx_valid=1 and rx_ready=1 in the same cycle: SHALL load the new byte, keep rx_valid=1 and leave overrun=0.
REQ-021 The receiver SHALL continue receiving while rx_valid=1; back-to-back frames, with the next start bit immediately after the stop sample, SHALL be received.
REQ-022 The counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL never wrap mid-bit.

Reset
REQ-023 While reset=1, SHALL force: state=IDLE, counter=0, index=0, shift=0x00, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rx_valid, frame_err or overrun.
REQ-025 After reset deasserts, SHALL wait for a new falling edge on rx_in.

Verification (CLKS_PER_BIT=16)
REQ-026 Send 0xA5 framed 8N1 with rx_ready=1 -> rx_data=0xA5, rx_valid high for 1 cycle, rx_valid rising 152-156 clks after the rx_in fall, frame_err=0.
REQ-027 Send 0x3C then 0x81 back-to-back with rx_ready=0; release rx_ready after the second frame -> rx_data=0x3C, overrun pulses once at the 0x81 stop sample, 0x81 is lost.
REQ-028 Drive rx_in low for 5 clks then high -> START rejects the glitch, with no rx_valid and no frame_err.
REQ-029 Send 0x55 with the stop bit driven 0 and the line held low for 40 bit periods -> exactly one frame_err pulse, rx_valid stays 0; next 0x0F frame after the line returns high -> rx_data=0x0F.
REQ-030 Assert reset for 3 clks at the DATA bit-4 point of a 0xFF frame -> all outputs 0 and no rx_valid; next frame 0x12 -> rx_data=0x12.
REQ-031 With rx_valid=1 (0x77 held), raise rx_ready in the exact completion cycle of 0x99 -> rx_data=0x99, rx_valid stays 1, overrun=0.
